// File: rtl/mult_div_unit_pkg.sv
// mult_div_defs: op codes, FSM states and latency helper shared by the
// iterative multiply/divide unit and its users.
package mult_div_defs;
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;

    localparam int MD_DEFAULT_WIDTH = 32;
    localparam int MD_LATENCY = MD_DEFAULT_WIDTH + 1;

    function automatic int md_latency(input int width);
        return width + 1;
    endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: one-bit-per-cycle shift-add multiplier / restoring divider
// with architectural HI/LO registers and a start/busy/done handshake.
module mult_div_unit
    import mult_div_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          r_state;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_signed;
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH:0]   w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_result;

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

    // Mult keeps {carry, partial high, multiplier}; div keeps {remainder, dividend/quotient}.
    always_comb begin
        w_sa     = ~op[0] & a[WIDTH-1];
        w_sb     = ~op[0] & b[WIDTH-1];
        w_amag   = w_sa ? -a : a;
        w_bmag   = w_sb ? -b : b;
        w_sum    = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_diff   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        w_step   = r_is_div ? (w_diff[WIDTH] ? {r_acc[2*WIDTH-1:0], 1'b0}
                                             : {w_diff, r_acc[WIDTH-2:0], 1'b1})
                            : {1'b0, w_sum, r_acc[WIDTH-1:1]};
        w_prod   = (r_signed & (r_sa ^ r_sb)) ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
        w_quo    = (r_signed & (r_sa ^ r_sb)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = (r_signed & r_sa) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_result = !r_is_div ? w_prod : r_bzero ? {r_a_raw, {WIDTH{1'b1}}} : {w_rem, w_quo};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !op[2]) begin
                        r_acc    <= {{(WIDTH+1){1'b0}}, op[1] ? w_amag : w_bmag};
                        r_opnd   <= op[1] ? w_bmag : w_amag;
                        r_a_raw  <= a;
                        r_is_div <= op[1];
                        r_signed <= ~op[0];
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_bzero  <= (b == '0);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_state  <= RUN;
                    end else if (start && op == MD_MTHI) begin
                        r_hi <= a;
                    end else if (start && op == MD_MTLO) begin
                        r_lo <= a;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    {r_hi, r_lo} <= w_result;
                    r_dbz        <= r_is_div & r_bzero;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven, hand-sequenced and random checks of
// mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_defs::*;

    localparam int W   = 32;
    localparam int LAT = md_latency(W);

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vt[10];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == MD_MULT) begin
            p = sx * sy;
            return {1'b0, p};
        end
        if (o == MD_MULTU) begin
            p = ux * uy;
            return {1'b0, p};
        end
        if (y == '0)
            return {1'b1, x, {W{1'b1}}};
        if (o == MD_DIV) begin
            sq = sx / sy;
            sr = sx % sy;
            return {1'b0, sr[W-1:0], sq[W-1:0]};
        end
        return {1'b0, 32'(ux % uy), 32'(ux / uy)};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                          input string name);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        int n;
        h0 = hi;
        l0 = lo;
        n = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy@accept"}, busy, 1);
        check({name, " dbz@accept"}, div_by_zero, 0);
        do begin
            @(posedge clk); #1;
            n++;
            if (n == W / 2) check({name, " hold"}, {hi, lo}, {h0, l0});
        end while (!done && n < 4 * LAT);
        check({name, " latency"}, n, LAT);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        check({name, " dbz"}, div_by_zero, ed);
        check({name, " busy@done"}, busy, 0);
    endtask

    initial begin
        logic [2*W:0] e;
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        logic [2:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int n;
        int pulses;

        vt[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[2] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[3] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vt[4] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[5] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vt[6] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[7] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vt[8] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vt[9] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {busy, done, div_by_zero, hi, lo}, '0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dbz, $sformatf("vec%0d", i));

        // done is a single-cycle pulse; the divide-by-zero flag persists after it
        @(posedge clk); #1;
        check("done width", done, 0);
        check("dbz sticky", div_by_zero, 1);

        // MTHI/MTLO when idle: single-cycle writes, flag untouched
        l0 = lo;
        start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi hi", hi, 32'hDEAD);
        check("mthi lo", lo, l0);
        check("mthi flags", {busy, done, div_by_zero}, 3'b001);
        start = 1'b1; op = MD_MTLO; a = 32'hBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo", {hi, lo}, {32'hDEAD, 32'hBEEF});

        // next accepted op clears the flag at its accept edge
        run_op(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "clr dbz");

        // starts while busy are ignored
        e = model(MD_MULTU, 32'd12345, 32'd6789);
        start = 1'b1; op = MD_MULTU; a = 32'd12345; b = 32'd6789;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = MD_DIVU; a = 32'd99; b = 32'd3;
        @(posedge clk); #1;
        op = MD_MTHI; a = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0;
        n = 6;
        while (!done && n < 4 * LAT) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy-ignore latency", n, LAT);
        check("busy-ignore result", {hi, lo}, e[2*W-1:0]);

        // back-to-back: accepted in the done cycle
        run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "b2b first");
        run_op(MD_DIVU, 32'd100, 32'd9, 32'd1, 32'd11, 1'b0, "b2b second");

        // reset aborts an in-flight divide
        start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort state", {busy, done, div_by_zero, hi, lo}, '0);
        pulses = 0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort no done", pulses, 0);
        check("abort no write", {hi, lo}, '0);
        run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after abort");

        // reset wins over start on the same edge
        reset = 1'b1; start = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("reset beats start", {busy, hi, lo}, '0);

        // random mult/div against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 8 == 0) ry = '0;
            if (i % 8 == 1) ry = 32'($urandom_range(1, 15));
            if (i % 8 == 2) ry = -32'($urandom_range(1, 15));
            e = model(ro, rx, ry);
            run_op(ro, rx, ry, e[2*W-1:W], e[W-1:0], e[2*W], $sformatf("rand%0d op%0d", i, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 0dMIPS execute stage, alongside the combinational alu. It runs signed/unsigned multiply and divide at one bit per cycle, width-parametrised, with a start/busy/done handshake. It also supports single-cycle MTHI/MTLO writes. The pipeline stalls on busy before MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; must be ≥ 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only when busy=0.
op  in  3  operation code, sampled with start.
a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
b  in  WIDTH  multiplier / divisor.
busy  out  1  operation in flight; new requests ignored.
done  out  1  one-cycle pulse when HI/LO hold a fresh mult/div result.
hi  out  WIDTH  HI register (product high half / remainder).
lo  out  WIDTH  LO register (product low half / quotient).
div_by_zero  out  1  last completed divide had b==0.

Behaviour:
- Op codes: MULT 000, MULTU 001, DIV 010, DIVU 011, MTHI 100, MTLO 101. Codes 110 and 111 are no-ops; start is ignored for them.
- Reset: on any edge with reset=1, state goes to IDLE and hi, lo, busy, done, div_by_zero all go to 0. Reset aborts an in-flight op with no result write.
- FSM: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 with a mult/div op (accept edge e0):
  - Latch |a|, |b| (magnitudes for signed ops, raw values for unsigned), op, and the sign bits.
  - Counter = 0; busy=1; div_by_zero=0; go to RUN.
- RUN: one shift-add (mult) or one restoring-subtract (div) step per edge. After WIDTH RUN edges (e1..eWIDTH), go to FIX.
- FIX edge e(WIDTH+1):
  - Apply sign correction and write hi/lo.
  - done=1 and busy=0 for exactly the following cycle; return to IDLE.
  - Total latency: results visible WIDTH+1 edges after the accept edge.
- Multiply: {hi,lo} = full 2·WIDTH-bit product. Signed ops negate the product when sign_a ^ sign_b.
- Divide, truncating toward zero:
  - Quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
  - DIV of MIN/-1 yields lo=MIN, hi=0, with no flag.
- Divide with b==0:
  - Takes the full latency.
  - Result is lo = all ones and hi = a as presented (raw, no sign handling).
  - div_by_zero=1 is written at the FIX edge; it stays set until the next accept edge or reset.
- MTHI/MTLO with busy=0:
  - Writes a into hi (or lo) at the accept edge; the other register is unchanged.
  - No busy, no done, div_by_zero unchanged.
- start while busy=1 (any op, including MTHI/MTLO): ignored entirely; the in-flight op is unaffected.
- Back-to-back: a start in the cycle done=1 is accepted, because state is IDLE.
- hi/lo hold their previous values throughout RUN; there are no intermediate results on the outputs.
- reset and start in the same edge: reset wins.

Decomposition:
- Shared package/header mult_div_defs:
  - op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - FSM state encoding IDLE/RUN/FIX;
  - latency constant MD_LATENCY = WIDTH+1.
- No sub-module needed; the iteration datapath (shift register, add/sub, counter) lives inline. The counter width is $clog2(WIDTH+1).

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy=1 after e0. At e33: hi=0xFFFFFFFE, lo=0x00000001, done high for exactly 1 cycle, busy=0.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done. The next accepted MULTU clears div_by_zero at its accept edge.
5. MULTU in flight; start DIVU and MTHI 0xDEAD at e5 -> both ignored, MULTU result correct. Then, when idle, MTHI 0xDEAD -> hi=0xDEAD next cycle, lo unchanged, done stays 0.
6. DIVU started, reset=1 at e10 -> next cycle busy=0, done=0, hi=lo=0. A new DIVU a=100 b=7 then gives lo=14, hi=2 at the normal latency.
